cms_axis_downsizer: RTL



---
 rtl/cms_axis_pkg.sv | 16 +
 rtl/cms_sat_counter.sv | 32 +++
 rtl/cms_axis_downsizer.sv | 106 ++++++++++
 3 files changed

// File: rtl/cms_axis_pkg.sv
// Shared widths and helpers for the CMS trace-to-DMA stream path.
// The downsizer states are plain 1-bit constants so older tools can consume them.
package cms_axis_pkg;

    localparam int CMS_AXI_DATA_WIDTH = 1024;
    localparam int CMS_DMA_DATA_WIDTH = 256;

    localparam logic [0:0] DS_EMPTY = 1'b0;
    localparam logic [0:0] DS_SEND  = 1'b1;

    // A legal split has a whole number of narrow slices, and at least two of them.
    function automatic bit width_ok(input int in_w, input int out_w);
        return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
    endfunction

endpackage

// File: rtl/cms_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so software
// can tell an overflowed count from a small one.
module cms_sat_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cms_axis_downsizer.sv
// Splits each wide CMS trace item into RATIO narrow beats, LSB slice first,
// and counts accepted items and downstream stall cycles.
module cms_axis_downsizer
    import cms_axis_pkg::*;
#(
    parameter int IN_WIDTH  = CMS_AXI_DATA_WIDTH,
    parameter int OUT_WIDTH = CMS_DMA_DATA_WIDTH,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tlast,
    output logic [CNT_WIDTH-1:0] item_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (!width_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_width
        $error("cms_axis_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
    end

    logic [IN_WIDTH-1:0]  buf_q, buf_d;
    logic [0:0]           full_q, full_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] item_q, item_d;

    logic on_last;
    logic in_hs;
    logic out_hs;

    assign on_last = (idx_q == LAST_IDX);

    // Ready depends combinationally on M_AXIS_tready so a new item can load
    // in the same cycle the last slice leaves, keeping the output gap-free.
    assign S_AXIS_tready = (full_q == DS_EMPTY) || (on_last && M_AXIS_tready);
    assign in_hs         = S_AXIS_tvalid && S_AXIS_tready;
    assign out_hs        = (full_q == DS_SEND) && M_AXIS_tready;

    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        idx_d  = idx_q;
        last_d = last_q;
        item_d = item_q;

        if (out_hs) begin
            if (on_last) begin
                full_d = DS_EMPTY;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // A load overrides the drain above when both land on the same edge.
        if (in_hs) begin
            buf_d  = S_AXIS_tdata;
            last_d = S_AXIS_tlast;
            idx_d  = '0;
            full_d = DS_SEND;
            item_d = item_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            full_q <= DS_EMPTY;
            idx_q  <= '0;
            last_q <= 1'b0;
            item_q <= '0;
        end else begin
            buf_q  <= buf_d;
            full_q <= full_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            item_q <= item_d;
        end
    end

    assign M_AXIS_tvalid = (full_q == DS_SEND);
    assign M_AXIS_tdata  = buf_q[int'(idx_q) * OUT_WIDTH +: OUT_WIDTH];
    assign M_AXIS_tlast  = (full_q == DS_SEND) && last_q && on_last;
    assign item_count    = item_q;

    cms_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .clear_i(rst),
        .inc_i  ((full_q == DS_SEND) && !M_AXIS_tready),
        .count_o(stall_count)
    );

endmodule
